tdm_mux8_serializer: RTL and testbench
======================================

Name: tdm_mux8_serializer

Overview:
- Transmit end of the 1-to-8 channel distribution path.
- Captures an 8-bit parallel word and sends it one bit per slot on a single line.
- Drives a 3-bit channel index `sel` alongside the bit, so a far-end 1-to-8 demux can steer each bit back to its own output.
- All outputs are registered; `en` paces the slots.

Parameters:
- MSB_FIRST, 0, 0: slot order channel 0..7 (sel counts up); 1: channel 7..0 (sel counts down).
- IDLE_LEVEL, 0, value driven on `out` while not transmitting.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- load  input  1  request to capture `din` and start a frame
- din  input  8  parallel word; bit k belongs to channel k
- en  input  1  slot advance enable; 0 holds the current slot
- a  output  1  serial bit for the current slot
- sel  output  3  channel index of the current slot
- valid  output  1  1 while `a`/`sel` carry frame data
- done  output  1  one-cycle pulse when a frame has been fully sent
- par  output  1  1 while the parity slot is on `a` (see Optional Feature)

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, a=IDLE_LEVEL, sel=0, valid=0, done=0, par=0, data register=0.
- States: IDLE, SEND, plus PARITY when the optional feature is compiled in.
- IDLE:
  - valid=0, a=IDLE_LEVEL, sel=0.
  - load=1 at edge N captures din into an internal 8-bit register.
  - At N+1: state=SEND, valid=1, sel=first channel (0, or 7 if MSB_FIRST), a=din[sel].
  - Latency from load to first valid bit: 1 cycle.
- SEND:
  - a = captured[sel] at all times (registered, updated together with sel).
  - en=1: sel steps to the next channel at the next edge.
  - en=0: sel, a and valid hold.
  - load during SEND is ignored; the captured data is not modified.
- Last slot (sel=7, or 0 if MSB_FIRST) with en=1:
  - Without parity: next cycle state=IDLE, valid=0, a=IDLE_LEVEL, done=1 for exactly one cycle.
  - With parity: go to PARITY (see Optional Feature).
- Back-to-back frames:
  - If load=1 at the same edge that ends a frame (last slot or parity slot with en=1), din is captured.
  - The next cycle is the first slot of the new frame: valid stays 1, done=1 for that cycle, no idle gap.
- sel arithmetic: 3-bit, never wraps within a frame; the frame terminates at the last channel.
- done is never asserted together with rst or in consecutive cycles from the same frame.
- rst=1 mid-frame: at the next edge all outputs take reset values, captured data is discarded, no done pulse. rst has priority over load.
- en is ignored in IDLE; load=0 in IDLE keeps the block idle indefinitely.

Optional Feature:
- Macro: TDM_MUX8_PARITY_EN.
- Defined:
  - After the last data slot with en=1, enter PARITY for one slot.
  - In PARITY: a = XOR of the 8 captured bits (even parity), sel holds the last channel, par=1, valid=1.
  - en=0 holds PARITY; en=1 ends the frame with done=1 next cycle (back-to-back rule applies).
- Not defined:
  - No PARITY state; `par` is tied to 0.
  - A frame is exactly 8 slots.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, load=0 -> a=IDLE_LEVEL, sel=0, valid=0, done=0, par=0.
- Basic frame, MSB_FIRST=0, en=1 constant: din=8'b1011_0010, load for 1 cycle -> from next cycle sel=0..7 with a=0,1,0,0,1,1,0,1; valid=1 for 8 cycles; then done=1 for 1 cycle and valid=0.
- Stall and MSB_FIRST=1: din=8'hA5, en low on alternate cycles -> sel=7,7,6,6,...,0,0; a matches din[sel]; frame takes 16 cycles; load pulses mid-frame do not change captured data.
- Back-to-back: load=1 with din=8'h0F during the last slot, en=1 -> next cycle done=1, valid=1, sel=0, a=1; no IDLE cycle between frames.
- Reset mid-frame: rst=1 while sel=4 -> next cycle all outputs at reset values, no done; a fresh load with din=8'hFF starts correctly at sel=0.
- TDM_MUX8_PARITY_EN defined: din=8'b0000_0111 -> 8 data slots, then one slot with par=1, a=1, sel=7, then done=1; with din=8'h03 the parity slot gives a=0.

Source files
------------

// File: rtl/tdm_mux8_serializer.sv
// 8-channel TDM serializer: captures a parallel byte and sends one bit per slot with its channel index.
// Optional even-parity slot after the data slots when TDM_MUX8_PARITY_EN is defined.
module tdm_mux8_serializer #(
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       en,
  output logic       a,
  output logic [2:0] sel,
  output logic       valid,
  output logic       done,
  output logic       par
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_PARITY} state_t;

  localparam logic [2:0] FIRST_CH = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST_CH  = MSB_FIRST ? 3'd0 : 3'd7;

  state_t     state_reg, state_next;
  logic [7:0] data_reg, data_next;
  logic       a_reg, a_next;
  logic [2:0] sel_reg, sel_next;
  logic       valid_reg, valid_next;
  logic       done_reg, done_next;
  logic [2:0] sel_step;
  logic       frame_end;

`ifdef TDM_MUX8_PARITY_EN
  logic par_reg, par_next;
`endif

  assign sel_step = MSB_FIRST ? (sel_reg - 3'd1) : (sel_reg + 3'd1);

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    a_next     = a_reg;
    sel_next   = sel_reg;
    valid_next = valid_reg;
    done_next  = 1'b0;
    frame_end  = 1'b0;
`ifdef TDM_MUX8_PARITY_EN
    par_next   = 1'b0;
`endif

    case (state_reg)
      S_IDLE: begin
      end
      S_SEND: begin
        if (en) begin
          if (sel_reg == LAST_CH) begin
`ifdef TDM_MUX8_PARITY_EN
            state_next = S_PARITY;
            a_next     = ^data_reg;
            par_next   = 1'b1;
`else
            frame_end  = 1'b1;
`endif
          end else begin
            sel_next = sel_step;
            a_next   = data_reg[sel_step];
          end
        end
      end
`ifdef TDM_MUX8_PARITY_EN
      S_PARITY: begin
        par_next = ~en;
        if (en) frame_end = 1'b1;
      end
`endif
      default: state_next = S_IDLE;
    endcase

    if (frame_end) begin
      done_next  = 1'b1;
      state_next = S_IDLE;
      valid_next = 1'b0;
      a_next     = IDLE_LEVEL;
      sel_next   = 3'd0;
    end

    // A load at the frame-ending edge starts the next frame with no idle gap.
    if (load && (state_reg == S_IDLE || frame_end)) begin
      state_next = S_SEND;
      data_next  = din;
      sel_next   = FIRST_CH;
      a_next     = din[FIRST_CH];
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      data_reg  <= 8'd0;
      a_reg     <= IDLE_LEVEL;
      sel_reg   <= 3'd0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      a_reg     <= a_next;
      sel_reg   <= sel_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
    end
  end

`ifdef TDM_MUX8_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) par_reg <= 1'b0;
    else     par_reg <= par_next;
  end
  assign par = par_reg;
`else
  assign par = 1'b0;
`endif

  assign a     = a_reg;
  assign sel   = sel_reg;
  assign valid = valid_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_tdm_mux8_serializer.sv
// Directed bench for tdm_mux8_serializer: LSB-first and MSB-first instances share stimulus.
module tb_tdm_mux8_serializer;

  logic       clk = 1'b0;
  logic       rst, load, en;
  logic [7:0] din;
  logic       a0, valid0, done0, par0;
  logic [2:0] sel0;
  logic       a1, valid1, done1, par1;
  logic [2:0] sel1;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  tdm_mux8_serializer #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .din(din), .en(en),
    .a(a0), .sel(sel0), .valid(valid0), .done(done0), .par(par0)
  );

  tdm_mux8_serializer #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .load(load), .din(din), .en(en),
    .a(a1), .sel(sel1), .valid(valid1), .done(done1), .par(par1)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic ea, input logic [2:0] es,
                      input logic ev, input logic ed, input logic ep);
    chk({tag, ".a"},     {7'b0, a0},     {7'b0, ea});
    chk({tag, ".sel"},   {5'b0, sel0},   {5'b0, es});
    chk({tag, ".valid"}, {7'b0, valid0}, {7'b0, ev});
    chk({tag, ".done"},  {7'b0, done0},  {7'b0, ed});
    chk({tag, ".par"},   {7'b0, par0},   {7'b0, ep});
  endtask

  task automatic chk1(input string tag, input logic ea, input logic [2:0] es,
                      input logic ev, input logic ed, input logic ep);
    chk({tag, ".a"},     {7'b0, a1},     {7'b0, ea});
    chk({tag, ".sel"},   {5'b0, sel1},   {5'b0, es});
    chk({tag, ".valid"}, {7'b0, valid1}, {7'b0, ev});
    chk({tag, ".done"},  {7'b0, done1},  {7'b0, ed});
    chk({tag, ".par"},   {7'b0, par1},   {7'b0, ep});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full LSB-first frame on dut0 with en held high.
  task automatic run_frame(input logic [7:0] word, input logic exp_par);
    din  = word;
    load = 1'b1;
    en   = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk0($sformatf("f%02h.s%0d", word, i), word[i], i[2:0], 1'b1, 1'b0, 1'b0);
      tick();
    end
`ifdef TDM_MUX8_PARITY_EN
    chk0($sformatf("f%02h.parity", word), exp_par, 3'd7, 1'b1, 1'b0, 1'b1);
    tick();
`endif
    chk0($sformatf("f%02h.done", word), 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk0($sformatf("f%02h.idle", word), 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    $display("frame din=%02h expected_parity=%0d sent", word, exp_par);
  endtask

  initial begin
    logic [7:0] w;
    logic [2:0] es;

    rst = 1'b1; load = 1'b0; en = 1'b0; din = 8'h00;
    tick(); tick();
    chk0("reset0", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk1("reset1", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    en  = 1'b1;
    tick(); tick();
    chk0("idle0", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    $display("reset and idle checked");

    // 1011_0010: four ones, even parity bit 0
    run_frame(8'b1011_0010, 1'b0);

    // MSB-first with alternate stalls and an ignored mid-frame load
    w = 8'hA5; din = w; load = 1'b1; en = 1'b1;
    tick();
    load = 1'b0;
    for (int j = 0; j < 16; j++) begin
      es = 3'(7 - j / 2);
      chk1($sformatf("msb.c%0d", j), w[es], es, 1'b1, 1'b0, 1'b0);
      en = j[0];
      if (j == 5) begin din = 8'h00; load = 1'b1; end
      else load = 1'b0;
      tick();
    end
`ifdef TDM_MUX8_PARITY_EN
    chk1("msb.parity", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    en = 1'b1;
    tick();
`endif
    chk1("msb.done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    en = 1'b1;
    tick();
    chk1("msb.idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    $display("frame din=A5 msb-first stalled sent");

    // Back-to-back: next load coincides with the frame-ending edge
    w = 8'h55; din = w; load = 1'b1; en = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk0($sformatf("b2b.s%0d", i), w[i], i[2:0], 1'b1, 1'b0, 1'b0);
`ifndef TDM_MUX8_PARITY_EN
      if (i == 7) begin load = 1'b1; din = 8'h0F; end
`endif
      tick();
    end
`ifdef TDM_MUX8_PARITY_EN
    chk0("b2b.parity", 1'b0, 3'd7, 1'b1, 1'b0, 1'b1);
    load = 1'b1; din = 8'h0F;
    tick();
`endif
    load = 1'b0;
    chk0("b2b.first", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk0("b2b.s1", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk0("b2b.s4", 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    $display("frame din=55 then 0F back-to-back sent");

    // Reset at sel=4 aborts the frame without a done pulse
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk0("abort0", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk1("abort1", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk0("abort.idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    $display("mid-frame reset checked");

    run_frame(8'hFF, 1'b0);
    run_frame(8'b0000_0111, 1'b1);
    run_frame(8'h03, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
